// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_pkg;

   localparam int unsigned BitCnt = 8;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWr,
      StWrAck,
      StRd,
      StRdAck,
      StWaitStop
   } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser, glitch filter and edge pulses for one I2C line.
// The filtered level only moves after FILT_CYC consecutive differing samples.
module i2c_line_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYC    = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CntW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CntW-1:0]        cnt_q;
   logic                   level_q;
   logic                   prev_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line};
         prev_q <= level_q;
         if (synced == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntW'(FILT_CYC - 1)) begin
            level_q <= synced;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;
   assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave with a byte register pointer, burst write/read and wrap-around.
// All logic runs on clk; SCL/SDA are oversampled through line filters.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYC    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        dev_addr,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              busy,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_waddr,
   output logic [7:0]        reg_wdata,
   output logic              rd_req,
   output logic [REG_AW-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [REG_AW-1:0] ptr,
   output logic              nack_evt
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC)
   ) u_scl_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (scl_i),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC)
   ) u_sda_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (sda_i),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   state_e            state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              rw_q, rw_d;
   logic [REG_AW-1:0] ptr_q, ptr_d;
   logic              sda_oe_q, sda_oe_d;
   logic              reg_we_q, reg_we_d;
   logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic              rd_req_q, rd_req_d;
   logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
   logic              nack_q, nack_d;
   logic              rd_pend_q;
   logic [7:0]        rd_buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         nack_q      <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_buf_q    <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         nack_q      <= nack_d;
         // rd_data is valid the cycle after rd_req; capture it then.
         rd_pend_q   <= rd_req_q;
         if (rd_pend_q) rd_buf_q <= rd_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      reg_we_d    = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      rd_req_d    = 1'b0;
      rd_addr_d   = rd_addr_q;
      nack_d      = 1'b0;

      case (state_q)
         StAddr, StPtr, StWr: begin
            if (scl_rise && bit_cnt_q != 4'(BitCnt)) begin
               shift_d   = {shift_q[6:0], sda_lvl};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (state_q == StWr && bit_cnt_q == 4'(BitCnt - 1)) begin
                  reg_we_d    = 1'b1;
                  reg_waddr_d = ptr_q;
                  reg_wdata_d = {shift_q[6:0], sda_lvl};
                  ptr_d       = ptr_q + REG_AW'(1);
               end
            end
            if (scl_fall && bit_cnt_q == 4'(BitCnt)) begin
               bit_cnt_d = '0;
               case (state_q)
                  StAddr: begin
                     if (shift_q[7:1] == dev_addr) begin
                        state_d  = StAddrAck;
                        rw_d     = shift_q[0];
                        sda_oe_d = 1'b1;
                     end else begin
                        state_d = StWaitStop;
                     end
                  end
                  StPtr: begin
                     ptr_d    = shift_q[REG_AW-1:0];
                     state_d  = StPtrAck;
                     sda_oe_d = 1'b1;
                  end
                  default: begin
                     state_d  = StWrAck;
                     sda_oe_d = 1'b1;
                  end
               endcase
            end
         end
         StAddrAck: begin
            if (scl_rise && rw_q) begin
               rd_req_d  = 1'b1;
               rd_addr_d = ptr_q;
            end
            if (scl_fall) begin
               bit_cnt_d = '0;
               if (rw_q) begin
                  state_d  = StRd;
                  shift_d  = rd_buf_q;
                  sda_oe_d = ~rd_buf_q[7];
               end else begin
                  state_d  = StPtr;
                  sda_oe_d = 1'b0;
               end
            end
         end
         StPtrAck, StWrAck: begin
            if (scl_fall) begin
               state_d   = StWr;
               bit_cnt_d = '0;
               sda_oe_d  = 1'b0;
            end
         end
         StRd: begin
            if (scl_rise && bit_cnt_q != 4'(BitCnt)) bit_cnt_d = bit_cnt_q + 4'd1;
            if (scl_fall && bit_cnt_q == 4'(BitCnt)) begin
               state_d  = StRdAck;
               sda_oe_d = 1'b0;
               ptr_d    = ptr_q + REG_AW'(1);
            end else if (scl_fall) begin
               shift_d  = {shift_q[6:0], 1'b0};
               sda_oe_d = ~shift_q[6];
            end
         end
         StRdAck: begin
            if (scl_rise) begin
               if (!sda_lvl) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = ptr_q;
               end else begin
                  nack_d  = 1'b1;
                  state_d = StWaitStop;
               end
            end
            if (scl_fall) begin
               state_d   = StRd;
               bit_cnt_d = '0;
               shift_d   = rd_buf_q;
               sda_oe_d  = ~rd_buf_q[7];
            end
         end
         default: ;
      endcase

      // Bus conditions override the byte engine but let a finished write strobe out.
      if (stop) begin
         state_d  = StIdle;
         sda_oe_d = 1'b0;
      end
      if (start) begin
         state_d   = StAddr;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = (state_q != StIdle);
   assign reg_we    = reg_we_q;
   assign reg_waddr = reg_waddr_q;
   assign reg_wdata = reg_wdata_q;
   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign ptr       = ptr_q;
   assign nack_evt  = nack_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged master, register model, vector tables.
module tb_i2c_reg_slave;

   logic       clk;
   logic       rst_n;
   logic       scl_m;
   logic       sda_m;
   logic       sda_bus;
   logic       sda_oe;
   logic       busy;
   logic       reg_we;
   logic [3:0] reg_waddr;
   logic [7:0] reg_wdata;
   logic       rd_req;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [3:0] ptr;
   logic       nack_evt;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_reg_slave #(
      .REG_AW      (4),
      .SYNC_STAGES (2),
      .FILT_CYC    (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dev_addr  (7'h42),
      .scl_i     (scl_m),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .reg_we    (reg_we),
      .reg_waddr (reg_waddr),
      .reg_wdata (reg_wdata),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .ptr       (ptr),
      .nack_evt  (nack_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model and event log.
   logic [3:0] we_addr_q[$];
   logic [7:0] we_data_q[$];
   logic [3:0] rd_addr_q[$];
   int         nack_cnt;
   int         oe_cnt;

   always @(posedge clk) begin
      if (!rst_n) begin
         rd_data  <= 8'h00;
      end else begin
         if (rd_req) rd_data <= 8'h30 + {4'h0, rd_addr};
         if (reg_we) begin
            we_addr_q.push_back(reg_waddr);
            we_data_q.push_back(reg_wdata);
         end
         if (rd_req) rd_addr_q.push_back(rd_addr);
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         nack_cnt <= 0;
         oe_cnt   <= 0;
      end else begin
         if (nack_evt) nack_cnt <= nack_cnt + 1;
         if (sda_oe) oe_cnt <= oe_cnt + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Quarter SCL period is 4 clk (40 time units); SCL = clk/16.
   task automatic i2c_start();
      sda_m = 1'b1; #40;
      scl_m = 1'b1; #40;
      sda_m = 1'b0; #40;
      scl_m = 1'b0; #40;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #40;
      scl_m = 1'b1; #40;
      sda_m = 1'b1; #80;
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; #40;
      scl_m = 1'b1; #80;
      scl_m = 1'b0; #40;
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; #40;
      scl_m = 1'b1; #40;
      b = sda_bus; #40;
      scl_m = 1'b0; #40;
   endtask

   task automatic put_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic get_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) get_bit(d[i]);
      put_bit(nack);
   endtask

   typedef struct {
      logic [3:0] waddr;
      logic [7:0] wdata;
   } wr_vec_t;

   typedef struct {
      logic [3:0] raddr;
      logic [7:0] rdata;
      logic       nack;
   } rd_vec_t;

   wr_vec_t wv[3];
   rd_vec_t rv[2];

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      int         we_base;
      int         rd_base;
      int         nack_base;
      int         oe_base;

      wv[0] = '{waddr: 4'hE, wdata: 8'hA1};
      wv[1] = '{waddr: 4'hF, wdata: 8'hB2};
      wv[2] = '{waddr: 4'h0, wdata: 8'hC3};
      rv[0] = '{raddr: 4'h5, rdata: 8'h35, nack: 1'b0};
      rv[1] = '{raddr: 4'h6, rdata: 8'h36, nack: 1'b1};

      rst_n = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      #50;
      rst_n = 1'b1;
      #20;
      check("reset sda_oe", sda_oe, 0);
      check("reset busy", busy, 0);
      check("reset reg_we", reg_we, 0);
      check("reset rd_req", rd_req, 0);
      check("reset nack_evt", nack_evt, 0);
      check("reset ptr", ptr, 0);
      check("reset reg_waddr", reg_waddr, 0);
      check("reset reg_wdata", reg_wdata, 0);
      check("reset rd_addr", rd_addr, 0);

      // Burst write with pointer wrap.
      we_base = we_addr_q.size();
      i2c_start();
      put_byte(8'h84, ack);
      check("bw addr ack", ack, 0);
      put_byte(8'h0E, ack);
      check("bw ptr ack", ack, 0);
      for (int i = 0; i < 3; i++) begin
         put_byte(wv[i].wdata, ack);
         check("bw data ack", ack, 0);
      end
      i2c_stop();
      #100;
      check("bw we count", we_addr_q.size() - we_base, 3);
      for (int i = 0; i < 3; i++) begin
         check("bw waddr", (we_base + i < we_addr_q.size()) ? 32'(we_addr_q[we_base + i]) : 'x,
               32'(wv[i].waddr));
         check("bw wdata", (we_base + i < we_data_q.size()) ? 32'(we_data_q[we_base + i]) : 'x,
               32'(wv[i].wdata));
      end
      check("bw ptr after", ptr, 1);
      check("bw busy after", busy, 0);

      // Combined read with repeated START.
      rd_base   = rd_addr_q.size();
      nack_base = nack_cnt;
      i2c_start();
      put_byte(8'h84, ack);
      check("cr addr w ack", ack, 0);
      put_byte(8'h05, ack);
      check("cr ptr ack", ack, 0);
      i2c_start();
      put_byte(8'h85, ack);
      check("cr addr r ack", ack, 0);
      for (int i = 0; i < 2; i++) begin
         get_byte(d, rv[i].nack);
         check("cr rd byte", d, rv[i].rdata);
      end
      i2c_stop();
      #100;
      check("cr rd_req count", rd_addr_q.size() - rd_base, 2);
      for (int i = 0; i < 2; i++) begin
         check("cr rd_addr", (rd_base + i < rd_addr_q.size()) ? 32'(rd_addr_q[rd_base + i]) : 'x,
               32'(rv[i].raddr));
      end
      check("cr nack count", nack_cnt - nack_base, 1);
      check("cr ptr after", ptr, 7);

      // Wrong address.
      we_base = we_addr_q.size();
      rd_base = rd_addr_q.size();
      oe_base = oe_cnt;
      i2c_start();
      put_byte(8'h86, ack);
      check("wa addr nack", ack, 1);
      check("wa busy mid", busy, 1);
      put_byte(8'h55, ack);
      check("wa data nack", ack, 1);
      check("wa busy before stop", busy, 1);
      i2c_stop();
      #100;
      check("wa busy after stop", busy, 0);
      check("wa sda_oe count", oe_cnt - oe_base, 0);
      check("wa we count", we_addr_q.size() - we_base, 0);
      check("wa rd count", rd_addr_q.size() - rd_base, 0);

      // Glitch rejection on SDA while SCL high.
      sda_m = 1'b0; #10; sda_m = 1'b1; #100;
      check("gl 1clk busy", busy, 0);
      sda_m = 1'b0; #20; sda_m = 1'b1; #100;
      check("gl 2clk busy", busy, 0);
      sda_m = 1'b0; #40; sda_m = 1'b1; #20;
      check("gl 4clk start", busy, 1);
      #100;
      check("gl 4clk then stop", busy, 0);

      // STOP inside a write byte.
      we_base = we_addr_q.size();
      i2c_start();
      put_byte(8'h84, ack);
      check("sb addr ack", ack, 0);
      put_byte(8'h09, ack);
      check("sb ptr ack", ack, 0);
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b1);
      i2c_stop();
      #100;
      check("sb we count", we_addr_q.size() - we_base, 0);
      check("sb busy", busy, 0);
      check("sb ptr kept", ptr, 9);

      // Reset while the slave drives a 0 read bit (ptr 9 -> data 0x39).
      i2c_start();
      put_byte(8'h85, ack);
      check("rr addr ack", ack, 0);
      #20;
      check("rr driving zero", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check("rr sda_oe released", sda_oe, 0);
      #9;
      check("rr busy", busy, 0);
      check("rr ptr", ptr, 0);
      check("rr reg_waddr", reg_waddr, 0);
      check("rr reg_wdata", reg_wdata, 0);
      check("rr rd_addr", rd_addr, 0);
      check("rr rd_req", rd_req, 0);
      check("rr reg_we", reg_we, 0);
      check("rr nack_evt", nack_evt, 0);
      sda_m = 1'b1;
      #20;
      rst_n = 1'b1;
      #40;
      scl_m = 1'b1;
      #100;

      we_base = we_addr_q.size();
      i2c_start();
      put_byte(8'h84, ack);
      check("pw addr ack", ack, 0);
      put_byte(8'h03, ack);
      check("pw ptr ack", ack, 0);
      put_byte(8'h5A, ack);
      check("pw data ack", ack, 0);
      i2c_stop();
      #100;
      check("pw we count", we_addr_q.size() - we_base, 1);
      check("pw waddr", (we_base < we_addr_q.size()) ? 32'(we_addr_q[we_base]) : 'x, 3);
      check("pw wdata", (we_base < we_data_q.size()) ? 32'(we_data_q[we_base]) : 'x, 32'h5A);
      check("pw ptr", ptr, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- Parametrised, fully synchronous I2C slave exposing a register space of 2^REG_AW bytes through an external register port, with pointer-based access and auto-increment.
- SCL/SDA are oversampled in the `clk` domain with synchroniser plus glitch filter; no logic is clocked by SCL.
- Supports repeated START, a pointer byte, burst write/read with wrap-around, and NACK/STOP handling in every state.
- Sits between the I2C pads and a system register file/CSR block.

Parameters:
- REG_AW, 4, register pointer width; register space is 2^REG_AW bytes.
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA (minimum 2).
- FILT_CYC, 3, consecutive identical samples required before a filtered line changes (minimum 1).

Ports:
- clk  in  1  system clock; at least 16x the SCL frequency.
- rst_n  in  1  asynchronous, active-low reset.
- dev_addr  in  7  own 7-bit I2C address.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open drain); the pad is tri-stated otherwise.
- busy  out  1  high whenever the state is not IDLE.
- reg_we  out  1  one-cycle write strobe.
- reg_waddr  out  REG_AW  write address.
- reg_wdata  out  8  write data.
- rd_req  out  1  one-cycle read request.
- rd_addr  out  REG_AW  read address.
- rd_data  in  8  read data; valid exactly 1 clk after rd_req.
- ptr  out  REG_AW  current register pointer (status).
- nack_evt  out  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset values: sda_oe=0, busy=0, reg_we=0, rd_req=0, nack_evt=0, ptr=0, reg_waddr=0, reg_wdata=0, rd_addr=0, state=IDLE, filtered lines=1. Reset mid-transfer releases SDA immediately.
- Input path: sync, then filter (output changes only after FILT_CYC equal samples), then edge detect.
  - Line-to-edge latency: SYNC_STAGES+FILT_CYC clk.
- Conditions on filtered lines:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - START has priority in any state and goes to ADDR (repeated START included); the bit counter is cleared.
  - STOP in any state goes to IDLE; sda_oe=0.
- Sampling and driving:
  - The slave samples SDA on the SCL rising-edge event.
  - It updates sda_oe on the SCL falling-edge event (same clk).
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th falling edge:
    - address match → ADDR_ACK (sda_oe=1);
    - otherwise → WAIT_STOP.
  - ADDR_ACK (one SCL bit): on the SCL rising edge, if R/W=1, rd_req with rd_addr=ptr.
    - On the falling edge: R → RD (load shifter with captured rd_data, drive MSB); W → PTR.
  - PTR: shift 8 bits, then PTR_ACK (ack). ptr is loaded from bits [REG_AW-1:0]; upper bits are ignored. Next state is WR.
  - WR: shift 8 bits, then WR_ACK (ack).
    - reg_we pulses 1 clk after the 8th rising edge, with reg_waddr=ptr, reg_wdata=byte.
    - Then ptr increments.
  - RD: drive shifter MSB-first; sda_oe = ~bit. After the 8th falling edge → RD_ACK; sda_oe=0. ptr increments at the end of the byte.
  - RD_ACK: sample the master's bit on the rising edge.
    - 0 (ACK) → rd_req with rd_addr=ptr; on the falling edge → RD with the new byte.
    - 1 (NACK) → nack_evt pulse, then WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- ptr arithmetic: increments modulo 2^REG_AW (0xF→0x0 for REG_AW=4).
  - ptr holds its value across transactions and STOP; reset is the only clear.
- Simultaneous reg_we and START: the write completes; START is still honoured.
- Unaddressed traffic produces no reg_we, no rd_req, and never drives SDA.
- The slave never stretches the clock.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP);
  - bit-count constant 8.
- Sub-module i2c_line_filter, instantiated twice (SCL, SDA): sync + glitch filter + rise/fall pulses, parameters SYNC_STAGES and FILT_CYC.

Test Plan (REG_AW=4, dev_addr=0x42, clk=16x SCL):
- Burst write with wrap: START, 0x84, ptr 0x0E, data 0xA1, 0xB2, 0xC3, STOP.
  - Three ACKs.
  - reg_we at addresses 0xE, 0xF, 0x0 with the matching data.
  - ptr=0x1 afterwards.
- Combined read: START, 0x84, ptr 0x05, repeated START, 0x85, read 2 bytes (ACK, then NACK), STOP. Model returns rd_data = addr+0x30.
  - Bytes 0x35, 0x36 on SDA.
  - rd_req at addresses 5 and 6.
  - Exactly one nack_evt.
  - ptr=0x7.
- Wrong address: START, 0x86, 0x55, STOP.
  - sda_oe stays 0.
  - No reg_we or rd_req.
  - busy=1 until STOP, then 0.
- Glitch rejection: 1-clk SDA low pulse while SCL is high in IDLE, then a 2-clk pulse (FILT_CYC=3).
  - No START detected; state stays IDLE.
  - A 4-clk pulse is detected as START.
- Reset mid-read: assert rst_n=0 while the slave drives a 0 bit.
  - sda_oe=0 within the same cycle.
  - All outputs return to reset values.
  - A following write transaction succeeds.
- STOP inside a byte: STOP after 3 data bits of WR.
  - No reg_we.
  - State IDLE, ptr unchanged.
